// File: rtl/bt_pkg.sv
// Shared types and constants for the HC-06 command parser and display helpers.
package bt_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEX_HI  = 3'd1,
        HEX_LO  = 3'd2,
        DIG_IDX = 3'd3,
        DIG_CHR = 3'd4,
        REPLY   = 3'd5
    } state_t;

    localparam logic [7:0] RSP_OK         = 8'h4B;
    localparam logic [7:0] RSP_ERR        = 8'h45;
    localparam logic [7:0] RSP_TMO        = 8'h54;

    localparam logic [7:0] SEG_BLANK      = 8'hFF;
    localparam logic [7:0] SEG_UNDERSCORE = 8'hEF;

    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_LF       = 8'h0A;

endpackage

// File: rtl/bt_ascii_to_seg.sv
// ASCII to 7-segment pattern (abcdefgP, active-low); letters are case-insensitive.
module bt_ascii_to_seg
    import bt_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [7:0] seg
);

    logic [7:0] folded;

    always_comb begin
        folded = ascii;
        if (ascii >= 8'h61 && ascii <= 8'h7A) begin
            folded = ascii & 8'hDF;
        end
        seg = SEG_UNDERSCORE;
        case (folded)
            "0": seg = 8'h03;
            "1": seg = 8'h9F;
            "2": seg = 8'h25;
            "3": seg = 8'h0D;
            "4": seg = 8'h99;
            "5": seg = 8'h49;
            "6": seg = 8'h41;
            "7": seg = 8'h1F;
            "8": seg = 8'h01;
            "9": seg = 8'h09;
            "A": seg = 8'h11;
            "B": seg = 8'hC1;
            "C": seg = 8'h63;
            "D": seg = 8'h85;
            "E": seg = 8'h61;
            "F": seg = 8'h71;
            "H": seg = 8'h91;
            "P": seg = 8'h31;
            "-": seg = 8'hFD;
            " ": seg = SEG_BLANK;
            default: seg = SEG_UNDERSCORE;
        endcase
    end

endmodule

// File: rtl/bt_cmd_parser.sv
// ASCII command parser for the HC-06 byte stream, replying K/E/T over valid/ready.
// Optional inter-byte timeout enabled by defining BT_CMD_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a command letter
// HEX_HI  | 'L' seen, waiting for high hex nibble
// HEX_LO  | waiting for low hex nibble
// DIG_IDX | 'D' seen, waiting for digit index '0'..'7'
// DIG_CHR | waiting for the character to display
// REPLY   | status byte pending on tx_data
module bt_cmd_parser
    import bt_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TIMEOUT_CYCLES = CLK_HZ / 2,
    parameter int NUM_DIGITS     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        carga,
    output logic [7:0]  leds,
    output logic [63:0] seg_buf,
    output logic        err_overrun
);

    state_t      state, state_d;
    logic        carga_d, tx_valid_d, err_d;
    logic [7:0]  leds_d, tx_data_d;
    logic [63:0] seg_d;
    logic [3:0]  hi_nib, hi_d;
    logic [2:0]  idx, idx_d;
    logic        rsp_go;
    logic [7:0]  rsp_code;
    logic [4:0]  hex;
    logic [7:0]  seg_code;
    logic        tmo_hit;

    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= "0" && c <= "9") begin
            r = {1'b1, c[3:0]};
        end else if ((c >= "a" && c <= "f") || (c >= "A" && c <= "F")) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

    bt_ascii_to_seg u_seg (
        .ascii (rx_data),
        .seg   (seg_code)
    );

`ifdef BT_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] tmo_cnt;
    logic             waiting;

    assign waiting = (state == HEX_HI) || (state == HEX_LO) ||
                     (state == DIG_IDX) || (state == DIG_CHR);
    // An arriving byte beats expiry in the same cycle.
    assign tmo_hit = waiting && !rx_valid &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (rx_valid || !waiting || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0) && (NUM_DIGITS != 0);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d    = state;
        carga_d    = carga;
        leds_d     = leds;
        seg_d      = seg_buf;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        err_d      = err_overrun;
        hi_d       = hi_nib;
        idx_d      = idx;
        rsp_go     = 1'b0;
        rsp_code   = RSP_OK;
        hex        = hex_decode(rx_data);

        case (state)
            IDLE: if (rx_valid) begin
                case (rx_data)
                    "A", "a": begin carga_d = 1'b1; rsp_go = 1'b1; end
                    "P", "p": begin carga_d = 1'b0; rsp_go = 1'b1; end
                    "L", "l": state_d = HEX_HI;
                    "D", "d": state_d = DIG_IDX;
                    ASCII_CR, ASCII_LF: state_d = IDLE;
                    default: begin rsp_go = 1'b1; rsp_code = RSP_ERR; end
                endcase
            end
            HEX_HI: if (rx_valid) begin
                if (hex[4]) begin
                    hi_d    = hex[3:0];
                    state_d = HEX_LO;
                end else begin
                    rsp_go = 1'b1; rsp_code = RSP_ERR;
                end
            end
            HEX_LO: if (rx_valid) begin
                rsp_go = 1'b1;
                if (hex[4]) leds_d = {hi_nib, hex[3:0]};
                else        rsp_code = RSP_ERR;
            end
            DIG_IDX: if (rx_valid) begin
                if (rx_data >= "0" && rx_data <= "7") begin
                    idx_d   = rx_data[2:0];
                    state_d = DIG_CHR;
                end else begin
                    rsp_go = 1'b1; rsp_code = RSP_ERR;
                end
            end
            DIG_CHR: if (rx_valid) begin
                seg_d[{idx, 3'b000} +: 8] = seg_code;
                rsp_go = 1'b1;
            end
            REPLY: begin
                if (rx_valid) err_d = 1'b1;
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tmo_hit) begin
            rsp_go   = 1'b1;
            rsp_code = RSP_TMO;
        end
        if (rsp_go) begin
            state_d    = REPLY;
            tx_valid_d = 1'b1;
            tx_data_d  = rsp_code;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            carga       <= 1'b0;
            leds        <= 8'h00;
            seg_buf     <= {8{SEG_BLANK}};
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            err_overrun <= 1'b0;
            hi_nib      <= 4'h0;
            idx         <= 3'd0;
        end else begin
            state       <= state_d;
            carga       <= carga_d;
            leds        <= leds_d;
            seg_buf     <= seg_d;
            tx_valid    <= tx_valid_d;
            tx_data     <= tx_data_d;
            err_overrun <= err_d;
            hi_nib      <= hi_d;
            idx         <= idx_d;
        end
    end

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Self-checking bench for bt_cmd_parser: vector table, directed corners, random vs. command-level model.
module tb_bt_cmd_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        carga;
    logic [7:0]  leds;
    logic [63:0] seg_buf;
    logic        err_overrun;

    int n_chk = 0;
    int n_err = 0;

`ifdef BT_CMD_TIMEOUT_EN
    localparam int TMO = 100;
    bt_cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
`else
    localparam int TMO = 0;
    bt_cmd_parser dut (
`endif
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .carga       (carga),
        .leds        (leds),
        .seg_buf     (seg_buf),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    // Command-level reference: bytes of a partial command are collected in a queue.
    logic       m_carga, m_pend, m_err;
    logic [7:0] m_leds, m_code;
    logic [7:0] m_seg [8];
    logic [7:0] q [$];
    int         m_gap;

    function automatic logic [7:0] up(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    function automatic int hexval(input logic [7:0] c);
        logic [7:0] u;
        u = up(c);
        if (u >= "0" && u <= "9") return int'(u) - 48;
        if (u >= "A" && u <= "F") return int'(u) - 55;
        return -1;
    endfunction

    function automatic logic [7:0] seg_ref(input logic [7:0] c);
        case (up(c))
            "0": return 8'h03;  "1": return 8'h9F;  "2": return 8'h25;
            "3": return 8'h0D;  "4": return 8'h99;  "5": return 8'h49;
            "6": return 8'h41;  "7": return 8'h1F;  "8": return 8'h01;
            "9": return 8'h09;  "A": return 8'h11;  "B": return 8'hC1;
            "C": return 8'h63;  "D": return 8'h85;  "E": return 8'h61;
            "F": return 8'h71;  "H": return 8'h91;  "P": return 8'h31;
            "-": return 8'hFD;  " ": return 8'hFF;
            default: return 8'hEF;
        endcase
    endfunction

    function automatic logic [63:0] m_seg_flat();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = m_seg[k];
        return r;
    endfunction

    task automatic model_reset();
        m_carga = 0; m_pend = 0; m_err = 0; m_leds = 8'h00; m_code = 8'h00;
        for (int k = 0; k < 8; k++) m_seg[k] = 8'hFF;
        q.delete();
        m_gap = 0;
    endtask

    task automatic m_reply(input logic [7:0] c);
        m_pend = 1; m_code = c; q.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic r);
        logic [7:0] u;
        int h;
        u = up(d);
        if (m_pend) begin
            if (v) m_err = 1;
            if (r) m_pend = 0;
            m_gap = 0;
        end else if (v) begin
            m_gap = 0;
            if (q.size() == 0) begin
                if (u == "A") begin m_carga = 1; m_reply(8'h4B); end
                else if (u == "P") begin m_carga = 0; m_reply(8'h4B); end
                else if (u == "L" || u == "D") q.push_back(u);
                else if (d != 8'h0D && d != 8'h0A) m_reply(8'h45);
            end else if (q[0] == "L") begin
                h = hexval(d);
                if (h < 0) m_reply(8'h45);
                else if (q.size() == 1) q.push_back(d);
                else begin
                    m_leds = 8'(hexval(q[1]) * 16 + h);
                    m_reply(8'h4B);
                end
            end else begin
                if (q.size() == 1) begin
                    if (d >= "0" && d <= "7") q.push_back(d);
                    else m_reply(8'h45);
                end else begin
                    m_seg[int'(q[1]) - 48] = seg_ref(d);
                    m_reply(8'h4B);
                end
            end
        end else if (TMO > 0 && q.size() > 0) begin
            m_gap++;
            if (m_gap == TMO) begin
                m_gap = 0;
                m_reply(8'h54);
            end
        end
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        rx_valid = v; rx_data = d; tx_ready = r;
        model_step(v, d, r);
        @(posedge clk);
        #1;
        rx_valid = 0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_carga"}, 64'(carga), 64'd0);
        check({nm, "_leds"}, 64'(leds), 64'h00);
        check({nm, "_seg"}, seg_buf, {64{1'b1}});
        check({nm, "_txv"}, 64'(tx_valid), 64'd0);
        check({nm, "_txd"}, 64'(tx_data), 64'h00);
        check({nm, "_err"}, 64'(err_overrun), 64'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ec;
        logic [7:0] el;
        logic       etv;
        logic [7:0] etd;
    } vec_t;

    vec_t tab [$];

    string alpha = "AaPpLlDd0123456789abcdefABCDEFG#- \r\nxHh7";
    logic [63:0] exp_seg;

    initial begin
        tab.push_back('{1'b1, "A", 1'b1, 8'h00, 1'b1, 8'h4B});
        tab.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00});
        tab.push_back('{1'b1, "p", 1'b0, 8'h00, 1'b1, 8'h4B});
        tab.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00});
        tab.push_back('{1'b1, "L", 1'b0, 8'h00, 1'b0, 8'h00});
        tab.push_back('{1'b1, "3", 1'b0, 8'h00, 1'b0, 8'h00});
        tab.push_back('{1'b1, "c", 1'b0, 8'h3C, 1'b1, 8'h4B});
        tab.push_back('{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h00});
        tab.push_back('{1'b1, 8'h0D, 1'b0, 8'h3C, 1'b0, 8'h00});
        tab.push_back('{1'b1, "L", 1'b0, 8'h3C, 1'b0, 8'h00});
        tab.push_back('{1'b1, "G", 1'b0, 8'h3C, 1'b1, 8'h45});
        tab.push_back('{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h00});
        tab.push_back('{1'b1, "a", 1'b1, 8'h3C, 1'b1, 8'h4B});
        tab.push_back('{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 8'h00});
        tab.push_back('{1'b1, "x", 1'b1, 8'h3C, 1'b1, 8'h45});
        tab.push_back('{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 8'h00});

        #3 reset = 1'b0;
        #1;
        model_reset();
        check_reset_vals("por");
        release_reset();

        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].v, tab[i].d, 1'b1);
            check($sformatf("vec%0d_carga", i), 64'(carga), 64'(tab[i].ec));
            check($sformatf("vec%0d_leds", i), 64'(leds), 64'(tab[i].el));
            check($sformatf("vec%0d_txv", i), 64'(tx_valid), 64'(tab[i].etv));
            if (tab[i].etv) check($sformatf("vec%0d_txd", i), 64'(tx_data), 64'(tab[i].etd));
        end

        // display digits
        send("D"); send("5"); send("7");
        exp_seg = {64{1'b1}};
        exp_seg[47:40] = 8'h1F;
        check("dig5_seg", seg_buf, exp_seg);
        check("dig5_txd", 64'(tx_valid ? tx_data : 8'h00), 64'h4B);
        idle(1);
        send("D"); send("9");
        check("dig9_txd", 64'(tx_valid ? tx_data : 8'h00), 64'h45);
        check("dig9_seg", seg_buf, exp_seg);
        idle(1);
        send("d"); send("0"); send("#");
        exp_seg[7:0] = 8'hEF;
        check("dig0_seg", seg_buf, exp_seg);
        idle(1);

        // overrun while reply is held off
        step(1'b1, "A", 1'b0);
        check("ovr_txv", 64'(tx_valid), 64'd1);
        step(1'b1, "P", 1'b0);
        check("ovr_err", 64'(err_overrun), 64'd1);
        check("ovr_carga", 64'(carga), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b0);
            check($sformatf("ovr_hold%0d", k), 64'({tx_valid, tx_data}), 64'h14B);
        end
        step(1'b0, 8'h00, 1'b1);
        check("ovr_done_txv", 64'(tx_valid), 64'd0);
        check("ovr_sticky", 64'(err_overrun), 64'd1);
        check("ovr_carga2", 64'(carga), 64'd1);

`ifdef BT_CMD_TIMEOUT_EN
        send("L");
        idle(99);
        check("tmo_pre_txv", 64'(tx_valid), 64'd0);
        idle(1);
        check("tmo_fire", 64'({tx_valid, tx_data}), 64'h154);
        check("tmo_leds", 64'(leds), 64'h3C);
        idle(1);
        check("tmo_done", 64'(tx_valid), 64'd0);
        send("L");
        idle(98);
        send("5");
        check("tmo_c99_txv", 64'(tx_valid), 64'd0);
        send("5");
        check("tmo_c99_leds", 64'({tx_valid, tx_data, leds}), 64'h14B55);
        idle(1);
        send("L");
        idle(99);
        send("2");
        check("tmo_tie_txv", 64'(tx_valid), 64'd0);
        send("4");
        check("tmo_tie_leds", 64'({tx_valid, tx_data, leds}), 64'h14B24);
        idle(1);
`else
        send("L");
        idle(300);
        check("notmo_txv", 64'(tx_valid), 64'd0);
        send("7"); send("E");
        check("notmo_leds", 64'({tx_valid, tx_data, leds}), 64'h14B7E);
        idle(1);
`endif

        // reset mid-command and mid-reply
        send("L"); send("1");
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_vals("rst_cmd");
        release_reset();
        idle(3);
        check("rst_cmd_quiet", 64'(tx_valid), 64'd0);
        send("2");
        check("rst_cmd_idle", 64'({tx_valid, tx_data}), 64'h145);
        idle(1);
        step(1'b1, "A", 1'b0);
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_vals("rst_rpl");
        release_reset();
        idle(3);
        check("rst_rpl_quiet", 64'({tx_valid, carga}), 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int k = 0; k < 105; k++) step(1'b0, 8'h00, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 1) == 1) begin
                step(1'b1, alpha[$urandom_range(0, alpha.len() - 1)], 1'($urandom_range(0, 9) < 6));
            end else begin
                step(1'b0, 8'($urandom), 1'($urandom_range(0, 9) < 6));
            end
            check($sformatf("rand%0d_ctl", i),
                  64'({carga, tx_valid, err_overrun, leds, tx_valid ? tx_data : 8'h00}),
                  64'({m_carga, m_pend, m_err, m_leds, m_pend ? m_code : 8'h00}));
            check($sformatf("rand%0d_seg", i), seg_buf, m_seg_flat());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
